// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter + APB master sequencer: NUM_REQ requesters share one APB slave, one transfer in flight.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that see no pready within TIMEOUT_CYCLES.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, win, win_q, cand;
    logic               any_valid, access_end, timeout;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !access_end) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    // pready landing on the expiry cycle completes the transfer normally.
    assign access_end = pready || timeout;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any_valid = |req_valid;
        win       = ptr;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[cand]) win = cand;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            ptr       <= '0;
            win_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= (state_d != IDLE);
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        req_ready <= onehot(win);
                        win_q     <= win;
                        psel      <= 1'b1;
                        pwrite    <= req_write[win];
                        paddr     <= req_addr[win*ADDR_W +: ADDR_W];
                        pwdata    <= req_wdata[win*DATA_W +: DATA_W];
                    end
                end
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    if (access_end) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        // Writes, slave errors and timeouts all return zero data.
                        rdata_q <= (pready && !pwrite && !pslverr) ? prdata : '0;
                        err_q   <= pready ? pslverr : 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= onehot(win_q);
                    rsp_rdata <= rdata_q;
                    rsp_err   <= err_q;
                    ptr       <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench for apb_rr_master_arbiter: directed APB transfers plus randomized multi-requester
// traffic checked against a transaction-level round-robin/memory reference model.
module tb_apb_rr_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic              rsp_err, busy, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]     paddr;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_rr_master_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // ---------------- APB slave: 32x32 RAM, error above word 31, programmable wait states ----------------
    int          slv_wait;
    bit          slv_noise;
    int          acc_cnt;
    logic [31:0] slv_mem [32];
    logic        addr_err;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    assign addr_err = (paddr[AW-1:5] != '0);
    assign pready   = psel && (penable ? (acc_cnt >= slv_wait) : slv_noise);
    assign pslverr  = psel && (addr_err || !pready);
    assign prdata   = (psel && penable && !addr_err) ? slv_mem[paddr[4:0]] : 32'hA5A5_5A5A;

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            acc_cnt <= 0;
            for (int i = 0; i < 32; i++) slv_mem[i] <= init_word(i);
        end else begin
            if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (psel && penable && pready && pwrite && !addr_err) slv_mem[paddr[4:0]] <= pwdata;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [32];
    int          m_ptr;
    int          glog[$];

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_xfer(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input bit timed_out, output logic [31:0] rdata, output logic err);
        err   = (addr[31:5] != '0) || timed_out;
        rdata = 32'h0;
        if (!err) begin
            if (wr) ref_mem[addr[4:0]] = data;
            else    rdata = ref_mem[addr[4:0]];
        end
        m_ptr = (r + 1) % N;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = data;
    endtask

    task automatic new_cmd(input int i);
        set_cmd(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom);
    endtask

    // One transfer from requester r alone; checks cycle-by-cycle APB timing and the response.
    task automatic single(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input int waits);
        logic [31:0] er;
        logic        ee;
        int          acc;
        bit          to;
`ifdef APB_ARB_TIMEOUT_EN
        to = (waits >= TO);
`else
        to = 1'b0;
`endif
        slv_wait  = waits;
        slv_noise = 1'b1;
        set_cmd(r, wr, addr, data);
        req_valid = N'(1) << r;
        tick();
        check("s_ready",   req_ready, 64'(N'(1) << r));
        check("s_setup",   {psel, penable, busy}, 3'b101);
        check("s_paddr",   paddr, addr);
        check("s_pwrite",  pwrite, wr);
        if (wr) check("s_pwdata", pwdata, data);
        req_valid = '0;
        set_cmd(r, ~wr, ~addr, ~data);
        model_xfer(r, wr, addr, data, to, er, ee);
        tick();
        check("s_access",  {psel, penable}, 2'b11);
        check("s_ready_0", req_ready, 0);
        acc = 0;
        while (psel && penable && acc < 200) begin
            acc++;
            tick();
        end
        check("s_acc_cycles", acc, to ? TO : waits + 1);
        check("s_done",    {psel, penable, busy}, 3'b001);
        check("s_done_rsp", rsp_valid, 0);
        check("s_paddr_held", paddr, addr);
        tick();
        check("s_rsp",      rsp_valid, 64'(N'(1) << r));
        check("s_rdata",    rsp_rdata, er);
        check("s_err",      rsp_err, ee);
        check("s_idle",     {busy, psel}, 2'b00);
    endtask

    // Multi-requester traffic; every grant is compared with the round-robin rule applied to the
    // request vector the DUT sampled, every response with the reference memory.
    task automatic traffic(input int n_xfers, input bit rnd);
        logic [N-1:0] vprev, got;
        logic [31:0]  er;
        logic         ee;
        int           owner, w, grants, rsps, cyc;
        owner = -1; grants = 0; rsps = 0; cyc = 0;
        er = '0; ee = 1'b0;
        slv_noise = rnd;
        slv_wait  = rnd ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < N; i++) begin
            new_cmd(i);
            req_valid[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        vprev = req_valid;
        while (cyc < 4000) begin
            cyc++;
            tick();
            got = '0;
            if (req_ready !== '0) begin
                w = rr_pick(vprev, m_ptr);
                check("t_grant", req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
                check("t_one_in_flight", grants - rsps, 0);
                check("t_setup", {psel, penable}, 2'b10);
                if (w >= 0) begin
                    check("t_paddr", paddr, req_addr[w*AW +: AW]);
                    model_xfer(w, req_write[w], req_addr[w*AW +: AW], req_wdata[w*DW +: DW], 1'b0, er, ee);
                    got[w] = 1'b1;
                    owner  = w;
                    glog.push_back(w);
                end
                grants++;
            end
            if (rsp_valid !== '0) begin
                check("t_rsp_owner", rsp_valid, (owner < 0) ? 64'd0 : (64'd1 << owner));
                check("t_rdata", rsp_rdata, er);
                check("t_err", rsp_err, ee);
                rsps++;
            end
            if (rsps >= n_xfers) break;
            for (int i = 0; i < N; i++) begin
                if (got[i]) begin
                    new_cmd(i);
                    req_valid[i] = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
                end else if (rnd && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                    new_cmd(i);
                    req_valid[i] = 1'b1;
                end
            end
            if (rnd) slv_wait = $urandom_range(0, 3);
            vprev = req_valid;
        end
        req_valid = '0;
        check("t_completed", rsps, n_xfers);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        preset    = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        slv_wait  = 0;
        slv_noise = 1'b0;
        #1 preset = 1'b1;
        model_reset();
        repeat (2) tick();
        check("rst_psel",      psel, 0);
        check("rst_penable",   penable, 0);
        check("rst_busy",      busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr",     paddr, 0);
        check("rst_pwdata",    pwdata, 0);
        check("rst_rsp",       {rsp_err, pwrite, rsp_rdata}, 0);
        preset = 1'b0;
        tick();
        check("idle_psel", psel, 0);

        single(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
        single(0, 1'b0, 32'd5, 32'h0, 0);
        check("readback_5", rsp_rdata, 32'hDEAD_BEEF);
        single(2, 1'b0, 32'd40, 32'h0, 1);
        check("slverr_err", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
        single(1, 1'b1, 32'd9, 32'hCAFE_F00D, TO - 1);
        single(3, 1'b0, 32'd9, 32'h0, 20);

        glog.delete();
        traffic(8, 1'b0);
        check("order_len", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) check("order", glog[k], k % N);

        traffic(40, 1'b1);

        single(2, 1'b1, 32'd10, 32'h0BAD_CAFE, 1);
        slv_wait  = 1000;
        slv_noise = 1'b0;
        set_cmd(1, 1'b0, 32'd3, 32'h0);
        req_valid = 4'b0010;
        tick();
        check("rst6_ready", req_ready, 4'b0010);
        req_valid = '0;
        repeat (3) tick();
        check("rst6_in_access", {psel, penable}, 2'b11);
        #2 preset = 1'b1;
        #1;
        check("rst6_async", {psel, penable, busy}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst6_no_rsp", {rsp_valid, psel}, 0);
        end
        preset = 1'b0;
        model_reset();
        tick();
        check("rst6_after", {rsp_valid, busy}, 0);
        glog.delete();
        traffic(4, 1'b0);
        check("rst6_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1, "watchdog");
    end

endmodule
